// File: rtl/aes_result_scroller.sv
// aes_result_scroller
// Display stage after the AES self-test. It captures a 128-bit result block and
// registers whether it equals the reference block. It then presents the block
// one byte at a time, most significant byte first, to the BCD/seven-segment
// converter. Each byte stays on byte_out for DWELL clock cycles.
//
// Parameters:
//   DWELL  cycles each byte is held (1 .. 2^26-1)
//   LOOP   0: one pass, then a done pulse; 1: wrap from byte 15 to byte 0
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   rst        synchronous active-high reset
//   mode[1:0]  key-size select; 2'b11 blanks and clears the display
//   blk_valid  one-cycle strobe qualifying blk_data/blk_ref
//   blk_data   result block; byte 0 is bits [127:120]
//   blk_ref    expected block
//   hold       freezes the dwell counter and byte index while high
//   byte_out   currently displayed byte
//   byte_idx   index (0..15) of byte_out
//   busy       high while scrolling
//   match      registered equality of the last captured block and its reference
//   done       one-cycle pulse at the end of a single pass
module aes_result_scroller #(
  parameter int DWELL = 4,
  parameter bit LOOP  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  input  logic [127:0] blk_ref,
  input  logic         hold,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         busy,
  output logic         match,
  output logic         done
);

  localparam logic [25:0] LAST_COUNT = 26'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t        state_reg, state_next;
  logic [127:0]  data_reg, data_next;
  logic [7:0]    byte_reg, byte_next;
  logic [3:0]    idx_reg, idx_next;
  logic          match_reg, match_next;
  logic [25:0]   cnt_reg, cnt_next;
  logic [1:0]    mode_reg;

  logic          blank;
  logic          mode_change;
  logic [3:0]    idx_inc;

  assign blank       = (mode == 2'b11);
  // Any difference from last cycle's mode counts as a key-size change.
  assign mode_change = (mode != mode_reg);
  assign idx_inc     = idx_reg + 4'd1;

  // Byte k occupies bits [127-8k -: 8]; for a 4-bit k, 15-k equals ~k.
  function automatic logic [7:0] pick(input logic [127:0] blk, input logic [3:0] idx);
    pick = blk[{~idx, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      byte_reg  <= '0;
      idx_reg   <= '0;
      match_reg <= 1'b0;
      cnt_reg   <= '0;
      mode_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      byte_reg  <= byte_next;
      idx_reg   <= idx_next;
      match_reg <= match_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    byte_next  = byte_reg;
    idx_next   = idx_reg;
    match_next = match_reg;
    cnt_next   = cnt_reg;

    if (blank) begin
      // Blanking clears the visible outputs in every state.
      state_next = IDLE;
      byte_next  = 8'h00;
      idx_next   = 4'd0;
      match_next = 1'b0;
      cnt_next   = '0;
    end else if (mode_change) begin
      // Abort without a done pulse. The visible byte and the match flag stay
      // as they are. This also overrides a strobe on the same edge.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (blk_valid) begin
            data_next  = blk_data;
            match_next = (blk_data == blk_ref);
            byte_next  = blk_data[127:120];
            idx_next   = 4'd0;
            cnt_next   = '0;
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (!hold) begin
            if (cnt_reg == LAST_COUNT) begin
              cnt_next = '0;
              if (idx_reg != 4'd15) begin
                idx_next  = idx_inc;
                byte_next = pick(data_reg, idx_inc);
              end else if (LOOP) begin
                idx_next  = 4'd0;
                byte_next = pick(data_reg, 4'd0);
              end else begin
                // Last byte stays visible after the pass ends.
                state_next = DONE;
              end
            end else begin
              cnt_next = cnt_reg + 26'd1;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign byte_out = byte_reg;
  assign byte_idx = idx_reg;
  assign match    = match_reg;
  assign busy     = (state_reg == SHOW);
  assign done     = (state_reg == DONE);

endmodule
